// File: rtl/cont_param.sv
// Parametrised up/down modulo counter with load, enable, prescaler, wrap/saturate mode,
// terminal-count pulse and sticky overflow flag.
module cont_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned DIV      = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] sa,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] MaxV  = MAX_VAL[WIDTH-1:0];
  localparam logic [PW-1:0]    PLast = PW'(DIV - 1);

  logic [WIDTH-1:0] sa_q, sa_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             boundary;

  assign step     = en & ~load & (pcnt_q == PLast);
  assign boundary = step & (up ? (sa_q == MaxV) : (sa_q == '0));

  always_comb begin
    sa_d   = sa_q;
    pcnt_d = pcnt_q;
    tc_d   = 1'b0;
    ovf_d  = ovf_q;
    if (load) begin
      sa_d   = (load_val > MaxV) ? MaxV : load_val;
      pcnt_d = '0;
    end else if (en) begin
      if (step) begin
        pcnt_d = '0;
        if (boundary) begin
          tc_d = 1'b1;
          // Saturate mode leaves sa untouched at the limit.
          if (SATURATE == 0) begin
            sa_d = up ? '0 : MaxV;
          end
        end else begin
          sa_d = up ? (sa_q + WIDTH'(1)) : (sa_q - WIDTH'(1));
        end
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
    // Set takes precedence over a coincident clear.
    if (boundary) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sa_q   <= '0;
      pcnt_q <= '0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sa_q   <= sa_d;
      pcnt_q <= pcnt_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign sa  = sa_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_cont_param.sv
// Directed bench for cont_param: four parameterisations share one stimulus bus.
module tb_cont_param;

  logic       clock;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic       clr_ovf;

  logic [3:0] sa_a, sa_b, sa_c, sa_d;
  logic       tc_a, tc_b, tc_c, tc_d;
  logic       ovf_a, ovf_b, ovf_c, ovf_d;

  int checks = 0;
  int errors = 0;

  cont_param #(.WIDTH(4)) u_a (
    .clock(clock), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .sa(sa_a), .tc(tc_a), .ovf(ovf_a)
  );
  cont_param #(.WIDTH(4), .MAX_VAL(9)) u_b (
    .clock(clock), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .sa(sa_b), .tc(tc_b), .ovf(ovf_b)
  );
  cont_param #(.WIDTH(4), .SATURATE(1)) u_c (
    .clock(clock), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .sa(sa_c), .tc(tc_c), .ovf(ovf_c)
  );
  cont_param #(.WIDTH(4), .DIV(3)) u_d (
    .clock(clock), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .sa(sa_d), .tc(tc_d), .ovf(ovf_d)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0; clr_ovf = 1'b0;
    #12;
    check("rst_sa", 32'(sa_a), 0);
    check("rst_tc", 32'(tc_a), 0);
    check("rst_ovf", 32'(ovf_a), 0);
    reset = 1'b1;

    // 1: full wrap count on the default instance
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("t1_sa", 32'(sa_a), 32'(k));
      check("t1_tc", 32'(tc_a), 0);
      check("t1_ovf", 32'(ovf_a), 0);
    end
    tick();
    check("t1_wrap_sa", 32'(sa_a), 0);
    check("t1_wrap_tc", 32'(tc_a), 1);
    check("t1_wrap_ovf", 32'(ovf_a), 1);
    tick();
    check("t1_post_sa", 32'(sa_a), 1);
    check("t1_post_tc", 32'(tc_a), 0);
    check("t1_post_ovf", 32'(ovf_a), 1);

    // 2: MAX_VAL=9 down-count with wrap to 9 and load clamp
    do_reset();
    load = 1'b1; load_val = 4'd2; tick();
    check("t2_load_sa", 32'(sa_b), 2);
    load = 1'b0; up = 1'b0;
    tick(); check("t2_sa1", 32'(sa_b), 1);
    tick(); check("t2_sa0", 32'(sa_b), 0);
    check("t2_tc0", 32'(tc_b), 0);
    tick(); check("t2_sa9", 32'(sa_b), 9);
    check("t2_tc9", 32'(tc_b), 1);
    check("t2_ovf9", 32'(ovf_b), 1);
    tick(); check("t2_sa8", 32'(sa_b), 8);
    check("t2_tc8", 32'(tc_b), 0);
    load = 1'b1; load_val = 4'd12; tick();
    check("t2_clamp", 32'(sa_b), 9);
    load = 1'b0; up = 1'b1; tick();
    check("t2_upwrap", 32'(sa_b), 0);

    // 3: saturate mode holds at 15 and pulses tc per step
    do_reset();
    load = 1'b1; load_val = 4'd14; tick();
    load = 1'b0; up = 1'b1; en = 1'b1;
    tick();
    check("t3_sa_a", 32'(sa_c), 15); check("t3_tc_a", 32'(tc_c), 0);
    check("t3_ovf_a", 32'(ovf_c), 0);
    tick();
    check("t3_sa_b", 32'(sa_c), 15); check("t3_tc_b", 32'(tc_c), 1);
    check("t3_ovf_b", 32'(ovf_c), 1);
    tick();
    check("t3_sa_c", 32'(sa_c), 15); check("t3_tc_c", 32'(tc_c), 1);
    en = 1'b0; clr_ovf = 1'b1; tick();
    check("t3_clr_ovf", 32'(ovf_c), 0); check("t3_clr_tc", 32'(tc_c), 0);
    check("t3_hold_sa", 32'(sa_c), 15);
    clr_ovf = 1'b0;

    // 4: DIV=3 prescaler, enable pause and load restart
    do_reset();
    en = 1'b1; up = 1'b1;
    tick(); check("t4_p1", 32'(sa_d), 0);
    tick(); check("t4_p2", 32'(sa_d), 0);
    tick(); check("t4_step1", 32'(sa_d), 1);
    tick(); check("t4_p4", 32'(sa_d), 1);
    en = 1'b0;
    tick(); tick(); check("t4_pause", 32'(sa_d), 1);
    en = 1'b1;
    tick(); check("t4_resume", 32'(sa_d), 1);
    tick(); check("t4_step2", 32'(sa_d), 2);
    tick(); check("t4_mid", 32'(sa_d), 2);
    load = 1'b1; load_val = 4'd5; tick();
    check("t4_load", 32'(sa_d), 5);
    load = 1'b0;
    tick(); check("t4_r1", 32'(sa_d), 5);
    tick(); check("t4_r2", 32'(sa_d), 5);
    tick(); check("t4_step3", 32'(sa_d), 6);

    // 5: load overrides count at MAX_VAL; clr_ovf loses to boundary
    do_reset();
    en = 1'b0; load = 1'b1; load_val = 4'd15; tick();
    load = 1'b0; en = 1'b1; up = 1'b1; tick();
    check("t5_wrap_ovf", 32'(ovf_a), 1);
    load = 1'b1; load_val = 4'd15; tick();
    check("t5_ld15_sa", 32'(sa_a), 15); check("t5_ld15_tc", 32'(tc_a), 0);
    load_val = 4'd3; tick();
    check("t5_ld3_sa", 32'(sa_a), 3); check("t5_ld3_tc", 32'(tc_a), 0);
    check("t5_ld3_ovf", 32'(ovf_a), 1);
    load_val = 4'd15; tick();
    load = 1'b0; clr_ovf = 1'b1; tick();
    check("t5_coinc_sa", 32'(sa_a), 0); check("t5_coinc_tc", 32'(tc_a), 1);
    check("t5_coinc_ovf", 32'(ovf_a), 1);
    tick();
    check("t5_clr_sa", 32'(sa_a), 1); check("t5_clr_ovf", 32'(ovf_a), 0);
    clr_ovf = 1'b0;

    // 6: asynchronous reset between edges
    load = 1'b1; load_val = 4'd15; tick();
    load = 1'b0; tick();
    check("t6_pre_tc", 32'(tc_a), 1); check("t6_pre_ovf", 32'(ovf_a), 1);
    tick();
    check("t6_pre_sa", 32'(sa_a), 1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_sa", 32'(sa_a), 0);
    check("t6_async_ovf", 32'(ovf_a), 0);
    tick();
    check("t6_held_sa", 32'(sa_a), 0);
    #2 reset = 1'b1;
    tick();
    check("t6_resume_sa", 32'(sa_a), 1);
    check("t6_resume_tc", 32'(tc_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
